// File: rtl/bcd_display_scanner.sv
// Iterative double-dabble binary-to-BCD converter with seven-segment display registers and a digit scanner.
// Optional signed (two's complement) input handling is enabled by defining BCD_DISPLAY_SIGNED_EN.
module bcd_display_scanner #(
    parameter int WIDTH    = 32,
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      value_i,
    input  logic                  load_i,
    input  logic                  blank_en_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  overflow_o,
    output logic [7*DIGITS-1:0]   seg_o,
    output logic [DIGITS-1:0]     scan_an_o,
    output logic [6:0]            scan_seg_o
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SH_W  = $clog2(WIDTH + 1);

    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            default: seg_of = SEG_BLANK;
        endcase
    endfunction

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      bin_q, bin_d, bin_sh;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d, bcd_adj, bcd_sh;
    logic [SH_W-1:0]       cnt_q, cnt_d;
    logic                  ovf_q, ovf_d, shift_out;
    logic                  blank_q, blank_d;
    logic                  neg_q, neg_d;
    logic                  busy_q, busy_d, done_q, done_d, overflow_q, overflow_d;
    logic [7*DIGITS-1:0]   seg_q, seg_d, disp_seg;
    logic                  disp_ovf;
    logic [CNT_W-1:0]      scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]      scan_idx_q, scan_idx_d;
    logic [DIGITS-1:0]     scan_an_q, scan_an_d;
    logic [6:0]            scan_seg_q, scan_seg_d;
    logic [WIDTH-1:0]      magnitude;
    int                    msd;
    int                    sign_pos;

    // One double-dabble step: add 3 to nibbles >= 5, then shift {bcd,bin} left.
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5)
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
        end
        shift_out        = bcd_adj[4*DIGITS-1];
        {bcd_sh, bin_sh} = {bcd_adj, bin_q} << 1;
    end

    always_comb begin
`ifdef BCD_DISPLAY_SIGNED_EN
        neg_d     = load_i ? value_i[WIDTH-1] : neg_q;
        magnitude = value_i[WIDTH-1] ? (~value_i + 1'b1) : value_i;
`else
        neg_d     = 1'b0;
        magnitude = value_i;
`endif
    end

    // Display image built from the final BCD result as it leaves the engine.
    always_comb begin
        msd = 0;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_sh[4*k +: 4] != 4'd0)
                msd = k;
        end
        disp_ovf = ovf_q | shift_out;
        sign_pos = DIGITS;
`ifdef BCD_DISPLAY_SIGNED_EN
        if (neg_q) begin
            if (msd == DIGITS - 1)
                disp_ovf = 1'b1;
            sign_pos = blank_q ? msd + 1 : DIGITS - 1;
        end
`endif
        for (int k = 0; k < DIGITS; k++) begin
            disp_seg[7*k +: 7] = seg_of(bcd_sh[4*k +: 4]);
            if (blank_q && k > msd)
                disp_seg[7*k +: 7] = SEG_BLANK;
            if (k == sign_pos)
                disp_seg[7*k +: 7] = SEG_DASH;
            if (disp_ovf)
                disp_seg[7*k +: 7] = SEG_DASH;
        end
    end

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        blank_d    = blank_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        seg_d      = seg_q;
        case (state_q)
            IDLE: begin
                if (load_i) begin
                    bin_d   = magnitude;
                    bcd_d   = '0;
                    ovf_d   = 1'b0;
                    blank_d = blank_en_i;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bin_d = bin_sh;
                bcd_d = bcd_sh;
                ovf_d = ovf_q | shift_out;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SH_W'(WIDTH - 1)) begin
                    state_d    = DONE;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    seg_d      = disp_seg;
                    overflow_d = disp_ovf;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        scan_idx_d = scan_idx_q;
        if (scan_cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            scan_idx_d = (scan_idx_q == IDX_W'(DIGITS - 1)) ? '0 : scan_idx_q + 1'b1;
        end
        scan_an_d  = ~(DIGITS'(1) << scan_idx_d);
        scan_seg_d = seg_q[7*int'(scan_idx_d) +: 7];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            blank_q    <= 1'b0;
            neg_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            seg_q      <= {DIGITS{SEG_ZERO}};
            scan_cnt_q <= '0;
            scan_idx_q <= '0;
            scan_an_q  <= ~DIGITS'(1);
            scan_seg_q <= SEG_ZERO;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            blank_q    <= blank_d;
            neg_q      <= (state_q == IDLE) ? neg_d : neg_q;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            seg_q      <= seg_d;
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
            scan_an_q  <= scan_an_d;
            scan_seg_q <= scan_seg_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign overflow_o = overflow_q;
    assign seg_o      = seg_q;
    assign scan_an_o  = scan_an_q;
    assign scan_seg_o = scan_seg_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench for bcd_display_scanner: directed and random conversions against a decimal
// arithmetic model, plus handshake timing, reset abort and scan sequencing checks.
module tb_bcd_display_scanner;

    localparam int WIDTH    = 32;
    localparam int DIGITS   = 8;
    localparam int SCAN_DIV = 4;

    logic                clk;
    logic                rst_n;
    logic [WIDTH-1:0]    value_i;
    logic                load_i;
    logic                blank_en_i;
    logic                busy_o;
    logic                done_o;
    logic                overflow_o;
    logic [7*DIGITS-1:0] seg_o;
    logic [DIGITS-1:0]   scan_an_o;
    logic [6:0]          scan_seg_o;

    int compares = 0;
    int fails    = 0;
    int t;
    logic [7*DIGITS-1:0] exp_segs;
    logic                exp_ovf;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    bcd_display_scanner #(.WIDTH(WIDTH), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .value_i(value_i), .load_i(load_i), .blank_en_i(blank_en_i),
        .busy_o(busy_o), .done_o(done_o), .overflow_o(overflow_o), .seg_o(seg_o),
        .scan_an_o(scan_an_o), .scan_seg_o(scan_seg_o)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of clock edges since the last reset edge, used to predict the scan position
    always @(posedge clk) begin
        if (!rst_n) t <= 0;
        else        t <= t + 1;
    end

    // Global watchdog so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Decimal reference: expected segment image and overflow from plain arithmetic
    function automatic void model(input logic [31:0] v, input logic blank,
                                  output logic [7*DIGITS-1:0] segs, output logic ovf);
        longint mag;
        longint p;
        bit     neg;
        int     nd;
        int     sign_pos;
        int     d;
        neg = 1'b0;
        mag = longint'(v);
`ifdef BCD_DISPLAY_SIGNED_EN
        if (v[31]) begin
            neg = 1'b1;
            mag = 64'sd4294967296 - longint'(v);
        end
`endif
        nd = 1;
        p  = 10;
        for (int k = 1; k < 11; k++) begin
            if (mag >= p) nd = k + 1;
            p = p * 10;
        end
        ovf      = (nd > DIGITS);
        sign_pos = -1;
        if (neg) begin
            if (blank) begin
                if (nd + 1 > DIGITS) ovf = 1'b1;
                sign_pos = nd;
            end else begin
                if (nd > DIGITS - 1) ovf = 1'b1;
                sign_pos = DIGITS - 1;
            end
        end
        p = 1;
        for (int k = 0; k < DIGITS; k++) begin
            d = int'((mag / p) % 10);
            segs[7*k +: 7] = seg_tab[d];
            if (blank && k >= nd) segs[7*k +: 7] = 7'b1111111;
            if (k == sign_pos)    segs[7*k +: 7] = 7'b0111111;
            if (ovf)              segs[7*k +: 7] = 7'b0111111;
            p = p * 10;
        end
    endfunction

    // One comparison: counts it, and on disagreement counts and reports the failure
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        compares++;
        assert (obs === expv) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, expv);
        end
    endtask

    // Run one conversion; optionally inject an extra load or a reset at a given cycle
    task automatic applyStimulus(input logic [31:0] v, input logic blank, input int intrude_at,
                                 input logic [31:0] intrude_val, input int reset_at);
        int busy_cnt;
        int done_at;
        int done_cnt;
        @(negedge clk);
        value_i    = v;
        blank_en_i = blank;
        load_i     = 1'b1;
        @(negedge clk);
        load_i   = 1'b0;
        busy_cnt = 0;
        done_at  = 0;
        done_cnt = 0;
        for (int i = 1; i <= 72; i++) begin
            if (busy_o === 1'b1) busy_cnt++;
            if (done_o === 1'b1) begin
                done_cnt++;
                if (done_at == 0) begin
                    done_at = i;
                    model(v, blank, exp_segs, exp_ovf);
                    checkOutput("seg_at_done", 64'(seg_o), 64'(exp_segs));
                    checkOutput("ovf_at_done", 64'(overflow_o), 64'(exp_ovf));
                    checkOutput("busy_at_done", 64'(busy_o), 64'd0);
                end
            end
            if (done_at != 0 && i == done_at + 1)
                checkOutput("done_pulse_width", 64'(done_o), 64'd0);
            if (reset_at != 0 && i == reset_at + 1) begin
                checkOutput("busy_after_reset", 64'(busy_o), 64'd0);
                rst_n = 1'b1;
            end
            if (i == intrude_at) begin
                value_i = intrude_val;
                load_i  = 1'b1;
            end else if (intrude_at != 0 && i == intrude_at + 1) begin
                load_i  = 1'b0;
                value_i = v;
            end
            if (reset_at != 0 && i == reset_at) rst_n = 1'b0;
            @(negedge clk);
        end
        if (reset_at == 0) begin
            checkOutput("busy_cycles", 64'(busy_cnt), 64'd32);
            checkOutput("done_cycle", 64'(done_at), 64'd33);
            checkOutput("done_count", 64'(done_cnt), 64'd1);
        end else begin
            exp_segs = {DIGITS{7'b1000000}};
            exp_ovf  = 1'b0;
            checkOutput("done_count_reset", 64'(done_cnt), 64'd0);
            checkOutput("seg_after_reset", 64'(seg_o), 64'(exp_segs));
            checkOutput("ovf_after_reset", 64'(overflow_o), 64'd0);
        end
    endtask

    // Scan position follows edges since reset; segments follow the expected display image
    task automatic scanCheck(input int n);
        int         idx;
        logic [7:0] an_exp;
        logic [6:0] sg_exp;
        for (int i = 0; i < n; i++) begin
            idx    = (t / SCAN_DIV) % DIGITS;
            an_exp = ~(8'b1 << idx);
            sg_exp = exp_segs[7*idx +: 7];
            checkOutput("scan_an", 64'(scan_an_o), 64'(an_exp));
            checkOutput("scan_seg", 64'(scan_seg_o), 64'(sg_exp));
            @(negedge clk);
        end
    endtask

    // Directed sequence
    initial begin
        logic [31:0] rv;
        longint      lim;
        int          d1;
        int          d2;
        rst_n      = 1'b0;
        load_i     = 1'b0;
        value_i    = '0;
        blank_en_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", 64'(busy_o), 64'd0);
        checkOutput("reset_done", 64'(done_o), 64'd0);
        checkOutput("reset_ovf", 64'(overflow_o), 64'd0);
        checkOutput("reset_seg", 64'(seg_o), 64'({DIGITS{7'b1000000}}));
        checkOutput("reset_scan_an", 64'(scan_an_o), 64'(8'b11111110));
        checkOutput("reset_scan_seg", 64'(scan_seg_o), 64'(7'b1000000));
        rst_n = 1'b1;

        applyStimulus(32'd12345678, 1'b0, 0, 32'd0, 0);
        applyStimulus(32'd42, 1'b1, 0, 32'd0, 0);
        applyStimulus(32'd0, 1'b1, 0, 32'd0, 0);
        applyStimulus(32'd100000000, 1'b0, 0, 32'd0, 0);
        applyStimulus(32'd7, 1'b0, 0, 32'd0, 0);
        applyStimulus(32'd99999999, 1'b1, 0, 32'd0, 0);
        applyStimulus(32'd5, 1'b0, 3, 32'd9, 0);
        applyStimulus(32'd12345678, 1'b0, 0, 32'd0, 10);

        applyStimulus(32'd87654321, 1'b1, 0, 32'd0, 0);
        scanCheck(40);

        // Load held high: a new conversion is accepted every WIDTH+2 cycles
        @(negedge clk);
        value_i    = 32'd314;
        blank_en_i = 1'b1;
        load_i     = 1'b1;
        d1 = 0;
        d2 = 0;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (done_o === 1'b1) begin
                if (d1 == 0)      d1 = i;
                else if (d2 == 0) d2 = i;
            end
        end
        load_i = 1'b0;
        checkOutput("b2b_first_done", 64'(d1), 64'd33);
        checkOutput("b2b_period", 64'(d2 - d1), 64'd34);
        repeat (40) @(negedge clk);

`ifdef BCD_DISPLAY_SIGNED_EN
        applyStimulus(32'hFFFF_FFD6, 1'b1, 0, 32'd0, 0);
        applyStimulus(32'hFFFF_FFFB, 1'b0, 0, 32'd0, 0);
        applyStimulus(32'h8000_0000, 1'b1, 0, 32'd0, 0);
        applyStimulus(32'hFA0A_1F01, 1'b0, 0, 32'd0, 0);
`endif

        for (int n = 0; n < 16; n++) begin
            lim = 1;
            for (int k = $urandom_range(1, 10); k > 0; k--) lim = lim * 10;
            rv = (lim >= 64'd10000000000) ? $urandom : 32'(longint'($urandom) % lim);
`ifdef BCD_DISPLAY_SIGNED_EN
            if ($urandom_range(0, 1) == 1) rv = -rv;
`endif
            applyStimulus(rv, 1'($urandom_range(0, 1)), 0, 32'd0, 0);
        end
        scanCheck(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule
